// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: merges the core's instruction-fetch and data-access
// sram-like request ports onto one downstream memory port. Only one
// transaction is in flight at a time. Data wins ties unless the instruction
// port has been passed over STARVE_MAX times in a row.
module sram_req_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  // instruction-fetch port
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data-access port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // downstream memory port
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  typedef enum logic {OWN_INST, OWN_DATA} owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;

  // Downstream request fields come straight from the latched copy so they
  // stay stable for however long the memory stalls the address phase.
  assign mem_wr    = wr_q;
  assign mem_size  = size_q;
  assign mem_addr  = addr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;

  // Read data is simply forwarded; it only matters alongside a data_ok.
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  // Next-state, grant selection and handshake outputs.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    mem_req      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Outputs are held quiet while reset is asserted.
        if (!reset) begin
          if (data_req && (!inst_req || starve_cnt_q != STARVE_LIM)) begin
            data_addr_ok = 1'b1;
            owner_d      = OWN_DATA;
            wr_d         = data_wr;
            size_d       = data_size;
            addr_d       = data_addr;
            wstrb_d      = data_wstrb;
            wdata_d      = data_wdata;
            state_d      = S_REQ;
            // Count only grants that actually pass over a waiting fetch.
            if (!inst_req) begin
              starve_cnt_d = 4'd0;
            end else if (starve_cnt_q != STARVE_LIM) begin
              starve_cnt_d = starve_cnt_q + 4'd1;
            end
          end else if (inst_req) begin
            inst_addr_ok = 1'b1;
            owner_d      = OWN_INST;
            wr_d         = inst_wr;
            size_d       = inst_size;
            addr_d       = inst_addr;
            wstrb_d      = inst_wstrb;
            wdata_d      = inst_wdata;
            starve_cnt_d = 4'd0;
            state_d      = S_REQ;
          end
        end
      end
      S_REQ: begin
        mem_req = !reset;
        if (mem_addr_ok) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_data_ok && !reset) begin
          inst_data_ok = (owner_q == OWN_INST);
          data_data_ok = (owner_q == OWN_DATA);
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched-request registers; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_INST;
      starve_cnt_q <= 4'd0;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= 32'd0;
      wstrb_q      <= 4'd0;
      wdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Randomized scoreboard bench for sram_req_arbiter. The driver runs a
// transaction-level model of the arbiter and pushes expected grants,
// downstream requests and completions into queues; an independent monitor
// pops them whenever the DUT shows the corresponding strobe.
module tb_sram_req_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int NCYC       = 3000;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } fields_t;

  typedef struct { int cyc; bit is_data; } addr_exp_t;
  typedef struct { int cyc; fields_t f; } mem_exp_t;
  typedef struct { int cyc; bit is_data; logic [31:0] rdata; } done_exp_t;

  logic        clk;
  logic        reset;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic [3:0]  inst_wstrb;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  addr_exp_t addr_q[$];
  mem_exp_t  mem_q[$];
  done_exp_t done_q[$];

  int cyc;
  int n_checks;
  int n_pass;
  int n_txn;

  sram_req_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name,
                     input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h required %0h", name, cyc, act, exp);
  endtask

  function automatic fields_t rand_fields();
    fields_t f;
    f.wr    = 1'($urandom_range(0, 1));
    f.size  = 2'($urandom_range(0, 2));
    f.addr  = $urandom();
    f.wstrb = 4'($urandom());
    f.wdata = $urandom();
    return f;
  endfunction

  function automatic logic [70:0] pack(fields_t f);
    return {f.wr, f.size, f.addr, f.wstrb, f.wdata};
  endfunction

  // Driver plus reference model.
  initial begin
    fields_t ip_f, dp_f, win_f;
    bit ip_pend, dp_pend, ip_on, dp_on, rst_now, prev_rst, drain, take_data, owner_data;
    int phase;   // 0: no transaction, 1: request not yet accepted, 2: awaiting completion
    int streak;  // data grants in a row while a fetch was waiting
    int pct;
    n_checks = 0; n_pass = 0; n_txn = 0; cyc = -1;
    ip_pend = 0; dp_pend = 0; prev_rst = 0; phase = 0; streak = 0; owner_data = 0;
    ip_f = rand_fields(); dp_f = rand_fields();
    reset = 1'b1;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;

    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk); #1;
      cyc     = k;
      drain   = (k >= NCYC - 40);
      rst_now = (k < 5) || (!drain && $urandom_range(0, 199) == 0);
      pct     = ((k / 400) % 3 == 0) ? 100 : (((k / 400) % 3 == 1) ? 60 : 30);
      if (!drain) begin
        if (!ip_pend && $urandom_range(1, 100) <= pct) begin ip_pend = 1; ip_f = rand_fields(); end
        if (!dp_pend && $urandom_range(1, 100) <= pct) begin dp_pend = 1; dp_f = rand_fields(); end
      end
      // Requests are withheld for the first cycle after reset.
      ip_on = ip_pend && !prev_rst;
      dp_on = dp_pend && !prev_rst;

      reset      = rst_now;
      inst_req   = ip_on;    inst_wr   = ip_f.wr;   inst_size  = ip_f.size;
      inst_addr  = ip_f.addr; inst_wstrb = ip_f.wstrb; inst_wdata = ip_f.wdata;
      data_req   = dp_on;    data_wr   = dp_f.wr;   data_size  = dp_f.size;
      data_addr  = dp_f.addr; data_wstrb = dp_f.wstrb; data_wdata = dp_f.wdata;
      mem_addr_ok = drain || ($urandom_range(0, 2) == 0);
      mem_data_ok = drain || ($urandom_range(0, 2) == 0);
      mem_rdata   = $urandom();

      if (rst_now) begin
        // An abandoned request never shows up downstream.
        while (mem_q.size() > 0 && mem_q[$].cyc >= k) void'(mem_q.pop_back());
        phase  = 0;
        streak = 0;
      end else if (phase == 0) begin
        if (ip_on || dp_on) begin
          take_data = dp_on && !(ip_on && streak == STARVE_MAX);
          win_f = take_data ? dp_f : ip_f;
          addr_q.push_back('{cyc: k, is_data: take_data});
          mem_q.push_back('{cyc: k + 1, f: win_f});
          if (take_data && ip_on) streak = (streak < STARVE_MAX) ? streak + 1 : STARVE_MAX;
          else streak = 0;
          if (take_data) dp_pend = 0; else ip_pend = 0;
          owner_data = take_data;
          phase = 1;
        end
      end else if (phase == 1) begin
        if (mem_addr_ok) phase = 2;
      end else begin
        if (mem_data_ok) begin
          done_q.push_back('{cyc: k, is_data: owner_data, rdata: mem_rdata});
          phase = 0;
        end
      end
      prev_rst = rst_now;
    end

    @(posedge clk); #1;
    cyc = NCYC;
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    @(negedge clk); #1;
    chk(addr_q.size() == 0, "grants_outstanding", 128'(addr_q.size()), 128'(0));
    chk(mem_q.size() == 0, "mem_req_outstanding", 128'(mem_q.size()), 128'(0));
    chk(done_q.size() == 0, "data_ok_outstanding", 128'(done_q.size()), 128'(0));
    chk(n_txn > 100, "txn_count", 128'(n_txn), 128'(101));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Monitor: compares DUT strobes against the scoreboard queues.
  initial begin
    addr_exp_t ae;
    mem_exp_t  cur;
    done_exp_t de;
    bit have_cur, prev_mreq, prev_maok, new_txn;
    logic [31:0] got_rdata;
    have_cur = 0; prev_mreq = 0; prev_maok = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} == 5'b0,
            "reset_quiet",
            128'({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 128'(0));
      end

      if (inst_addr_ok || data_addr_ok) begin
        chk(addr_q.size() != 0, "addr_ok_expected", 128'({inst_addr_ok, data_addr_ok}), 128'(0));
        if (addr_q.size() != 0) begin
          ae = addr_q.pop_front();
          chk(ae.cyc == cyc && data_addr_ok == ae.is_data && inst_addr_ok == !ae.is_data,
              "addr_ok_grant",
              128'({32'(cyc), inst_addr_ok, data_addr_ok}),
              128'({32'(ae.cyc), !ae.is_data, ae.is_data}));
        end
      end

      new_txn = mem_req && (!prev_mreq || prev_maok);
      if (new_txn) begin
        chk(mem_q.size() != 0, "mem_req_expected", 128'(mem_addr), 128'(0));
        have_cur = (mem_q.size() != 0);
        if (have_cur) begin
          cur = mem_q.pop_front();
          chk(cur.cyc == cyc, "mem_req_cycle", 128'(cyc), 128'(cur.cyc));
        end
      end
      if (mem_req && have_cur) begin
        chk({mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata} == pack(cur.f), "mem_fields",
            128'({mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata}), 128'(pack(cur.f)));
      end
      prev_mreq = mem_req;
      prev_maok = mem_addr_ok;

      if (inst_data_ok || data_data_ok) begin
        chk(done_q.size() != 0, "data_ok_expected", 128'({inst_data_ok, data_data_ok}), 128'(0));
        if (done_q.size() != 0) begin
          de = done_q.pop_front();
          got_rdata = data_data_ok ? data_rdata : inst_rdata;
          chk(de.cyc == cyc && data_data_ok == de.is_data && inst_data_ok == !de.is_data,
              "data_ok_owner",
              128'({32'(cyc), inst_data_ok, data_data_ok}),
              128'({32'(de.cyc), !de.is_data, de.is_data}));
          chk(got_rdata == de.rdata, "rdata", 128'(got_rdata), 128'(de.rdata));
          n_txn++;
          $display("txn %0d: %s port done at cycle %0d rdata=%08h",
                   n_txn, de.is_data ? "data" : "inst", cyc, got_rdata);
        end
      end
    end
  end

endmodule
